alu_sequencer: RTL

- Initiator-side controller for the team's 8-bit ALU.
- Accepts an operation request (op, A, B) over a valid/ready handshake and drives the ALU's operand, op and output-enable inputs.
- Holds those inputs stable through the ALU's one-clock registered execution, then captures the ALU result and flags.
- Returns the result and flags on a valid/ready response port and maintains the architectural flags register {C,N,O,Z} for the control unit.

---
 rtl/alu_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Initiator-side controller for the 8-bit ALU: accepts a request, holds ALU
// inputs through the registered execute cycle, captures result/flags and returns them.
module alu_sequencer #(
  parameter int          DATA_W    = 8,
  parameter logic [3:0]  FLAG_MASK = 4'b1111,
  parameter logic [2:0]  CMP_OP    = 3'b101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              rsp_wb,
  output logic [3:0]        flags_q,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_out_en,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

  state_e              state_q,     state_d;
  logic                req_ready_q, req_ready_d;
  logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
  logic [2:0]          alu_op_q,    alu_op_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic [3:0]          rsp_flags_q, rsp_flags_d;
  logic                rsp_wb_q,    rsp_wb_d;
  logic [3:0]          flags_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_wb_d    = rsp_wb_q;
    flags_d     = flags_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          alu_op_d = req_op;
          state_d  = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        // alu_result is only driven by the ALU while alu_out_en is high, i.e. here.
        rsp_data_d  = alu_result;
        rsp_flags_d = alu_flags;
        rsp_wb_d    = (alu_op_q != CMP_OP);
        flags_d     = (flags_q & ~FLAG_MASK) | (alu_flags & FLAG_MASK);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered so req_ready is low during reset and has no path from req_valid.
    req_ready_d = (state_d == IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_wb_q    <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_wb_q    <= rsp_wb_d;
      flags_q     <= flags_d;
    end
  end

  // Decoded from state alone, so reset releases the ALU bus immediately.
  assign alu_out_en = (state_q == CAPT);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_wb     = rsp_wb_q;

endmodule
